// File: rtl/demo_seq_ctrl.sv
// Test sequencer for a 2-input combinational gate: walks (a,b) through 00,10,01,11,
// samples c at the end of each hold window and scores the truth table against EXPECTED.
module demo_seq_ctrl #(
  parameter int unsigned HOLD_CYCLES = 100,
  parameter int unsigned CNT_W       = 8,
  parameter logic [3:0]  EXPECTED    = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_c,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic       pass,
  output logic [3:0] err_mask
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       cap_q, cap_d;
  logic             gate_a_q, gate_a_d;
  logic             gate_b_q, gate_b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       truth_q, truth_d;
  logic             pass_q, pass_d;
  logic [3:0]       err_mask_q, err_mask_d;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    cnt_d      = cnt_q;
    cap_d      = cap_q;
    gate_a_d   = 1'b0;
    gate_b_d   = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    truth_d    = truth_q;
    pass_d     = pass_q;
    err_mask_d = err_mask_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          step_d  = 2'd0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          busy_d   = 1'b1;
          gate_a_d = step_q[0];
          gate_b_d = step_q[1];
          if (cnt_q == CNT_LAST) begin
            cap_d[step_q] = gate_c;
            cnt_d         = '0;
            step_d        = step_q + 2'd1;
            gate_a_d      = step_d[0];
            gate_b_d      = step_d[1];
            // Results are loaded on the final sample edge so they appear alongside done.
            if (step_q == 2'd3) begin
              state_d    = DONE;
              busy_d     = 1'b0;
              done_d     = 1'b1;
              gate_a_d   = 1'b0;
              gate_b_d   = 1'b0;
              truth_d    = cap_d;
              pass_d     = (cap_d == EXPECTED);
              err_mask_d = cap_d ^ EXPECTED;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= 2'd0;
      cnt_q      <= '0;
      cap_q      <= 4'd0;
      gate_a_q   <= 1'b0;
      gate_b_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      truth_q    <= 4'd0;
      pass_q     <= 1'b0;
      err_mask_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
      gate_a_q   <= gate_a_d;
      gate_b_q   <= gate_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      truth_q    <= truth_d;
      pass_q     <= pass_d;
      err_mask_q <= err_mask_d;
    end
  end

  assign gate_a   = gate_a_q;
  assign gate_b   = gate_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign truth    = truth_q;
  assign pass     = pass_q;
  assign err_mask = err_mask_q;

endmodule

// File: tb/tb_demo_seq_ctrl.sv
// Directed bench for demo_seq_ctrl: one instance with HOLD_CYCLES=4 (AND/XOR gate model)
// and one with HOLD_CYCLES=1 (AND gate) for the back-to-back restart case.
module tb_demo_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, xor_mode;
  logic       gate_a, gate_b, gate_c, busy, done, pass;
  logic [3:0] truth, err_mask;

  logic       start2, abort2;
  logic       gate_a2, gate_b2, gate_c2, busy2, done2, pass2;
  logic [3:0] truth2, err_mask2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign gate_c  = xor_mode ? (gate_a ^ gate_b) : (gate_a & gate_b);
  assign gate_c2 = gate_a2 & gate_b2;

  demo_seq_ctrl #(.HOLD_CYCLES(4), .CNT_W(8), .EXPECTED(4'b1000)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .gate_a(gate_a), .gate_b(gate_b), .gate_c(gate_c),
    .busy(busy), .done(done), .truth(truth), .pass(pass), .err_mask(err_mask)
  );

  demo_seq_ctrl #(.HOLD_CYCLES(1), .CNT_W(8), .EXPECTED(4'b1000)) dut_h1 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2),
    .gate_a(gate_a2), .gate_b(gate_b2), .gate_c(gate_c2),
    .busy(busy2), .done(done2), .truth(truth2), .pass(pass2), .err_mask(err_mask2)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; xor_mode = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, gate_b, gate_a} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl got %b want 0000", {busy, done, gate_b, gate_a});
    end
    n_tests++;
    if ({truth, pass, err_mask} !== 9'd0) begin
      n_fail++; $display("FAIL reset_result got %b want 000000000", {truth, pass, err_mask});
    end
    n_tests++;
    if ({busy2, done2, gate_b2, gate_a2, truth2, pass2, err_mask2} !== 13'd0) begin
      n_fail++; $display("FAIL reset_h1 got %b want 0", {busy2, done2, gate_b2, gate_a2, truth2, pass2, err_mask2});
    end
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_idle got %b want 00", {busy, done});
    end
    $display("[TB] test_reset done");
  endtask

  // Full run with a one-cycle start pulse, checking every cycle of the 16-cycle window.
  task automatic do_run(input logic xor_m, input logic [3:0] exp_truth,
                        input logic exp_pass, input logic [3:0] exp_err, input string name);
    logic [1:0] st;
    xor_mode = xor_m;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      st = 2'(k / 4);
      n_tests++;
      if ({busy, done, gate_b, gate_a} !== {2'b10, st[1], st[0]}) begin
        n_fail++; $display("FAIL %s_ctl cycle=%0d got %b want %b", name, k + 1,
                           {busy, done, gate_b, gate_a}, {2'b10, st[1], st[0]});
      end
      @(negedge clk);
    end
    n_tests++;
    if ({busy, done, gate_b, gate_a} !== 4'b0100) begin
      n_fail++; $display("FAIL %s_done got %b want 0100", name, {busy, done, gate_b, gate_a});
    end
    n_tests++;
    if ({truth, pass, err_mask} !== {exp_truth, exp_pass, exp_err}) begin
      n_fail++; $display("FAIL %s_result got %b want %b", name, {truth, pass, err_mask},
                         {exp_truth, exp_pass, exp_err});
    end
    @(negedge clk);
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL %s_after got %b want 00", name, {busy, done});
    end
    $display("[TB] run %s truth=%b pass=%b err_mask=%b", name, truth, pass, err_mask);
  endtask

  task automatic test_and();
    do_run(1'b0, 4'b1000, 1'b1, 4'b0000, "and");
  endtask

  task automatic test_xor();
    do_run(1'b1, 4'b0110, 1'b0, 4'b1110, "xor");
  endtask

  task automatic test_abort();
    xor_mode = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_tests++;
    if ({busy, done, gate_b, gate_a} !== 4'b0000) begin
      n_fail++; $display("FAIL abort_ctl got %b want 0000", {busy, done, gate_b, gate_a});
    end
    n_tests++;
    if ({truth, pass, err_mask} !== {4'b1000, 1'b1, 4'b0000}) begin
      n_fail++; $display("FAIL abort_result got %b want 100010000", {truth, pass, err_mask});
    end
    repeat (20) begin
      @(negedge clk);
      n_tests++;
      if ({busy, done} !== 2'b00) begin
        n_fail++; $display("FAIL abort_idle got %b want 00", {busy, done});
      end
    end
    $display("[TB] test_abort done");
  endtask

  task automatic test_rst_mid();
    xor_mode = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy, done, gate_b, gate_a, truth, pass, err_mask} !== 13'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs got %b want 0", {busy, done, gate_b, gate_a, truth, pass, err_mask});
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_idle got %b want 00", {busy, done});
    end
    $display("[TB] test_rst_mid reset phase done");
    do_run(1'b0, 4'b1000, 1'b1, 4'b0000, "post_rst");
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_seq [12];
    exp_seq = '{4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0100, 4'b0000,
                4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0100, 4'b0000};
    @(negedge clk); start2 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_tests++;
      if ({busy2, done2, gate_b2, gate_a2} !== exp_seq[i]) begin
        n_fail++; $display("FAIL b2b_ctl idx=%0d got %b want %b", i, {busy2, done2, gate_b2, gate_a2}, exp_seq[i]);
      end
      if (i == 4 || i == 10) begin
        n_tests++;
        if ({truth2, pass2, err_mask2} !== {4'b1000, 1'b1, 4'b0000}) begin
          n_fail++; $display("FAIL b2b_result idx=%0d got %b want 100010000", i, {truth2, pass2, err_mask2});
        end
      end
      if (i == 6) start2 = 1'b0;
      if (i == 7) start2 = 1'b1;
    end
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_start_abort();
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    n_tests++;
    if ({busy, done, gate_b, gate_a} !== 4'b0000) begin
      n_fail++; $display("FAIL start_abort_ctl got %b want 0000", {busy, done, gate_b, gate_a});
    end
    @(negedge clk);
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++; $display("FAIL start_abort_idle got %b want 00", {busy, done});
    end
    n_tests++;
    if (truth !== 4'b1000) begin
      n_fail++; $display("FAIL start_abort_truth got %b want 1000", truth);
    end
    $display("[TB] test_start_abort done");
  endtask

  initial begin
    test_reset();
    test_and();
    test_abort();
    test_xor();
    test_rst_mid();
    test_back_to_back();
    test_start_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
